// File: rtl/cursor_controller.sv
// rtl/cursor_controller.sv - push-button cursor stepper with debounce, auto-repeat and clamping
module cursor_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 2500000,
  parameter int STEP            = 1,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [1:0]  sel,
  output logic [10:0] cursorX1,
  output logic [10:0] cursorX2,
  output logic [10:0] cursorY1,
  output logic [10:0] cursorY2,
  output logic        step_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  // bit 0 = up, bit 1 = down
  logic [1:0]    sync1, sync2, deb;
  logic [DW-1:0] db_cnt [2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic [1:0] dir;
  always_comb begin
    dir = DIR_NONE;
    if (deb == 2'b01) dir = DIR_UP;
    else if (deb == 2'b10) dir = DIR_DOWN;
  end

  logic [1:0]    state, state_n;
  logic [1:0]    dir_q, dir_q_n;
  logic [TW-1:0] timer, timer_n;
  logic          step_req;

  always_comb begin
    state_n  = state;
    dir_q_n  = dir_q;
    timer_n  = timer;
    step_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (dir != DIR_NONE) begin
          step_req = 1'b1;
          dir_q_n  = dir;
          timer_n  = '0;
          state_n  = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dir != dir_q) begin
          state_n = S_IDLE;
        end else if (timer == TW'(REPEAT_DELAY - 1)) begin
          step_req = 1'b1;
          timer_n  = '0;
          state_n  = S_REPEAT;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_REPEAT: begin
        if (dir != dir_q) begin
          state_n = S_IDLE;
        end else if (timer == TW'(REPEAT_RATE - 1)) begin
          step_req = 1'b1;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      dir_q <= DIR_NONE;
      timer <= '0;
    end else begin
      state <= state_n;
      dir_q <= dir_q_n;
      timer <= timer_n;
    end
  end

  logic [10:0] pos [4];
  logic [11:0] cur, limit, sum, nxt;

  // 12-bit arithmetic so an overshoot above the limit is visible before clamping
  always_comb begin
    cur   = {1'b0, pos[sel]};
    limit = sel[1] ? 12'(Y_MAX) : 12'(X_MAX);
    sum   = cur + 12'(STEP);
    nxt   = cur;
    if (dir_q_n == DIR_UP) begin
      nxt = (sum > limit) ? limit : sum;
    end else if (dir_q_n == DIR_DOWN) begin
      nxt = (cur < 12'(STEP)) ? 12'd0 : cur - 12'(STEP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos[0]     <= 11'd32;
      pos[1]     <= 11'd90;
      pos[2]     <= 11'd25;
      pos[3]     <= 11'd100;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (step_req) begin
        pos[sel]   <= nxt[10:0];
        step_pulse <= (nxt != cur);
      end
    end
  end

  assign cursorX1 = pos[0];
  assign cursorX2 = pos[1];
  assign cursorY1 = pos[2];
  assign cursorY2 = pos[3];

endmodule
